// File: rtl/led_pattern_pkg.sv
// Shared mode/phase encodings and start-pattern helper for the LED pattern generator.
package led_pattern_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    localparam logic [1:0] MODE_FILL_CLEAR = 2'd0;
    localparam logic [1:0] MODE_FILL_DRAIN = 2'd1;
    localparam logic [1:0] MODE_RUN        = 2'd2;
    localparam logic [1:0] MODE_PINGPONG   = 2'd3;

    localparam logic PH_UP   = 1'b0;
    localparam logic PH_DOWN = 1'b1;

    // Empty bar for the fill modes, single lit LSB for the moving-dot modes.
    function automatic logic [MAX_WIDTH-1:0] start_pattern(input logic [1:0] mode,
                                                           input int unsigned width);
        logic [MAX_WIDTH-1:0] mask;
        mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
        if (mode == MODE_RUN || mode == MODE_PINGPONG) begin
            return MAX_WIDTH'(1) & mask;
        end
        return '0;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Clock-enable tick generator: one-cycle TICK every DIV enabled cycles, freezes while EN = 0.
module step_tick_gen #(
    parameter int unsigned DIV = 50000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign TICK    = EN & at_last & ~CLR;

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Parametrised LED sequencer: four selectable WIDTH-bit patterns, one step per DIV clock cycles.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 50000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic             STEP,
    output logic             WRAP
);

    logic [WIDTH-1:0] q_q, q_d, nxt_q;
    logic             ph_q, ph_d, nxt_ph;
    logic [1:0]       mode_q, mode_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             mode_chg;
    logic [WIDTH-1:0] start_cur;
    logic [WIDTH-1:0] start_new;

    assign mode_chg  = (MODE != mode_q);
    assign start_cur = WIDTH'(start_pattern(mode_q, WIDTH));
    assign start_new = WIDTH'(start_pattern(MODE, WIDTH));

    step_tick_gen #(.DIV(DIV)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .CLR  (mode_chg),
        .TICK (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= start_new;
            ph_q   <= PH_UP;
            mode_q <= MODE;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            ph_q   <= ph_d;
            mode_q <= mode_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    // Pattern that the next step would show; phase flips on the step that reaches the end pattern.
    always_comb begin
        nxt_q  = q_q;
        nxt_ph = ph_q;
        unique case (mode_q)
            MODE_FILL_CLEAR, MODE_FILL_DRAIN: begin
                if (ph_q == PH_UP) begin
                    nxt_q = {q_q[WIDTH-2:0], 1'b1};
                    if (nxt_q == {WIDTH{1'b1}}) nxt_ph = PH_DOWN;
                end else begin
                    if (mode_q == MODE_FILL_CLEAR) nxt_q = {q_q[WIDTH-2:0], 1'b0};
                    else                           nxt_q = {1'b0, q_q[WIDTH-1:1]};
                    if (nxt_q == '0) nxt_ph = PH_UP;
                end
            end
            MODE_RUN: begin
                nxt_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            end
            default: begin
                if (ph_q == PH_UP) begin
                    nxt_q = {q_q[WIDTH-2:0], 1'b0};
                    if (nxt_q[WIDTH-1]) nxt_ph = PH_DOWN;
                end else begin
                    nxt_q = {1'b0, q_q[WIDTH-1:1]};
                    if (nxt_q[0]) nxt_ph = PH_UP;
                end
            end
        endcase
    end

    // Mode change restarts the sequence and outranks a coincident tick.
    always_comb begin
        q_d    = q_q;
        ph_d   = ph_q;
        mode_d = mode_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (mode_chg) begin
            mode_d = MODE;
            q_d    = start_new;
            ph_d   = PH_UP;
        end else if (tick) begin
            q_d    = nxt_q;
            ph_d   = nxt_ph;
            step_d = 1'b1;
            wrap_d = (nxt_q == start_cur);
        end
    end

    assign Q    = q_q;
    assign STEP = step_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: five configurations share stimulus and are checked against a sequence-index model.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       en;

    always #5 clk = ~clk;

    logic [7:0] q0;
    logic [3:0] q1;
    logic [1:0] q2;
    logic [3:0] q3;
    logic [3:0] q4;
    logic       s_a [5];
    logic       w_a [5];
    logic [7:0] q_a [5];

    led_pattern_gen #(.WIDTH(8), .DIV(1)) u0 (.CLK(clk), .RST(rst), .MODE(mode), .EN(en), .Q(q0), .STEP(s_a[0]), .WRAP(w_a[0]));
    led_pattern_gen #(.WIDTH(4), .DIV(3)) u1 (.CLK(clk), .RST(rst), .MODE(mode), .EN(en), .Q(q1), .STEP(s_a[1]), .WRAP(w_a[1]));
    led_pattern_gen #(.WIDTH(2), .DIV(1)) u2 (.CLK(clk), .RST(rst), .MODE(mode), .EN(en), .Q(q2), .STEP(s_a[2]), .WRAP(w_a[2]));
    led_pattern_gen #(.WIDTH(4), .DIV(4)) u3 (.CLK(clk), .RST(rst), .MODE(mode), .EN(en), .Q(q3), .STEP(s_a[3]), .WRAP(w_a[3]));
    led_pattern_gen #(.WIDTH(4), .DIV(1)) u4 (.CLK(clk), .RST(rst), .MODE(mode), .EN(en), .Q(q4), .STEP(s_a[4]), .WRAP(w_a[4]));

    assign q_a[0] = q0;
    assign q_a[1] = {4'b0, q1};
    assign q_a[2] = {6'b0, q2};
    assign q_a[3] = {4'b0, q3};
    assign q_a[4] = {4'b0, q4};

    int W_A [5] = '{8, 4, 2, 4, 4};
    int D_A [5] = '{1, 3, 1, 4, 1};

    int         m_cnt  [5];
    int         m_k    [5];
    logic [1:0] m_mode [5];
    logic       m_step [5];
    logic       m_wrap [5];

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       en;
        logic [7:0] exp_q;
        logic       exp_step;
        logic       exp_wrap;
    } vec_t;

    function automatic int period(input logic [1:0] md, input int w);
        case (md)
            2'd0, 2'd1: return 2 * w;
            2'd2:       return w;
            default:    return 2 * w - 2;
        endcase
    endfunction

    // Pattern shown at position k of a mode's cycle, from the sequence definitions.
    function automatic logic [7:0] pat(input logic [1:0] md, input int k, input int w);
        int full;
        full = (1 << w) - 1;
        case (md)
            2'd0:    return 8'((k <= w) ? (1 << k) - 1 : full & ~((1 << (k - w)) - 1));
            2'd1:    return 8'((k <= w) ? (1 << k) - 1 : (1 << (2 * w - k)) - 1);
            2'd2:    return 8'(1 << k);
            default: return 8'((k < w) ? (1 << k) : (1 << (2 * w - 2 - k)));
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 5; i++) begin
            m_step[i] = 1'b0;
            m_wrap[i] = 1'b0;
            if (rst || mode != m_mode[i]) begin
                m_mode[i] = mode;
                m_k[i]    = 0;
                m_cnt[i]  = 0;
            end else if (en) begin
                if (m_cnt[i] == D_A[i] - 1) begin
                    m_cnt[i]  = 0;
                    m_k[i]    = (m_k[i] + 1) % period(m_mode[i], W_A[i]);
                    m_step[i] = 1'b1;
                    m_wrap[i] = (m_k[i] == 0);
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    // Advance one clock and compare every instance against the model.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("u%0d_q", i), q_a[i], pat(m_mode[i], m_k[i], W_A[i]));
            chk($sformatf("u%0d_step", i), 8'(s_a[i]), 8'(m_step[i]));
            chk($sformatf("u%0d_wrap", i), 8'(w_a[i]), 8'(m_wrap[i]));
        end
    endtask

    vec_t       tbl [17];
    logic [7:0] fc8 [16];
    logic [3:0] pp4 [6];
    logic [1:0] pp2 [6];

    initial begin
        fc8 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        pp4 = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
        pp2 = '{2'h2, 2'h1, 2'h2, 2'h1, 2'h2, 2'h1};
        tbl[0] = '{rst: 1'b1, mode: 2'd0, en: 1'b1, exp_q: 8'h00, exp_step: 1'b0, exp_wrap: 1'b0};
        for (int i = 0; i < 16; i++) begin
            tbl[i+1] = '{rst: 1'b0, mode: 2'd0, en: 1'b1, exp_q: fc8[i],
                         exp_step: 1'b1, exp_wrap: (i == 15)};
        end
        for (int i = 0; i < 5; i++) begin
            m_cnt[i] = 0; m_k[i] = 0; m_mode[i] = 2'd0; m_step[i] = 1'b0; m_wrap[i] = 1'b0;
        end
        rst = 1'b1; mode = 2'd0; en = 1'b0;

        // FILL_CLEAR on WIDTH=8, DIV=1 from the vector table
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; mode = tbl[i].mode; en = tbl[i].en;
            cycle();
            chk($sformatf("tbl%0d_q", i), q0, tbl[i].exp_q);
            chk($sformatf("tbl%0d_step", i), 8'(s_a[0]), 8'(tbl[i].exp_step));
            chk($sformatf("tbl%0d_wrap", i), 8'(w_a[0]), 8'(tbl[i].exp_wrap));
        end

        // FILL_DRAIN on DIV=3: first step three cycles after reset release, then mode switch on a due tick
        rst = 1'b1; mode = 2'd1; en = 1'b1;
        cycle();
        rst = 1'b0;
        cycle(); chk("fd_first_step_c1", 8'(s_a[1]), 8'h0);
        cycle(); chk("fd_first_step_c2", 8'(s_a[1]), 8'h0);
        cycle(); chk("fd_first_step_c3", 8'(s_a[1]), 8'h1); chk("fd_first_q", 8'(q1), 8'h1);
        cycle(); cycle();
        mode = 2'd2;
        cycle();
        chk("modechg_q", 8'(q1), 8'h1);
        chk("modechg_step", 8'(s_a[1]), 8'h0);
        cycle(); chk("modechg_nostep1", 8'(s_a[1]), 8'h0);
        cycle(); chk("modechg_nostep2", 8'(s_a[1]), 8'h0);
        cycle(); chk("modechg_step3", 8'(s_a[1]), 8'h1); chk("modechg_q3", 8'(q1), 8'h2);

        // RUN on DIV=4 with a 10-cycle pause after two counting cycles
        rst = 1'b1; mode = 2'd2; en = 1'b1;
        cycle();
        rst = 1'b0;
        cycle(); cycle();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("pause_q", 8'(q3), 8'h1);
            chk("pause_step", 8'(s_a[3]), 8'h0);
        end
        en = 1'b1;
        cycle(); chk("resume_c1_step", 8'(s_a[3]), 8'h0);
        cycle(); chk("resume_c2_step", 8'(s_a[3]), 8'h1); chk("resume_q", 8'(q3), 8'h2);

        // PINGPONG on WIDTH=4 and WIDTH=2
        rst = 1'b1; mode = 2'd3; en = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("pp4_q%0d", i), 8'(q4), 8'(pp4[i]));
            chk($sformatf("pp4_wrap%0d", i), 8'(w_a[4]), 8'(pp4[i] == 4'h1));
            chk($sformatf("pp2_q%0d", i), 8'(q2), 8'(pp2[i]));
            chk($sformatf("pp2_wrap%0d", i), 8'(w_a[2]), 8'(pp2[i] == 2'h1));
        end

        // Reset mid-sequence while MODE moves to PINGPONG
        rst = 1'b1; mode = 2'd0; en = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("midrst_pre_q", q0, 8'h3F);
        rst = 1'b1; mode = 2'd3;
        cycle();
        chk("midrst_q", q0, 8'h01);
        chk("midrst_step", 8'(s_a[0]), 8'h0);
        chk("midrst_wrap", 8'(w_a[0]), 8'h0);
        rst = 1'b0;
        cycle();
        chk("midrst_next_q", q0, 8'h02);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
